ahb_master_biu: RTL and testbench
=================================

Name: ahb_master_biu

Overview:
Parametrised AHB-Lite master bus interface unit for the pipelined RV32I core. It arbitrates NUM_CH cache/debug requesters (ch0 = I-cache, ch1 = D-cache, higher = debug/DMA) onto the single AHB master port. It issues single or burst transfers with a pipelined address/data phase, wait-state handling and two-cycle ERROR response handling. It replaces direct PC-driven HADDR/HTRANS assignments with one owned bus master.

Parameters:
NUM_CH, 2, number of requester channels (1..4)
MAX_BEATS, 8, maximum beats per transaction (power of 2, ≤16)
ARB_MODE, "FIXED", "FIXED" = lowest index wins; "RR" = round-robin starting after last granted channel

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
ch_req  input  NUM_CH  per-channel request; held high until ch done
ch_addr  input  NUM_CH*32  start address, channel i at [32i+31:32i]
ch_write  input  NUM_CH  1 = write transaction
ch_size  input  NUM_CH*3  HSIZE encoding (0 byte, 1 half, 2 word)
ch_beats  input  NUM_CH*5  beat count 1..MAX_BEATS; 0 treated as 1
ch_wdata  input  NUM_CH*32  current write word of channel
ch_gnt  output  NUM_CH  one-hot grant, held for whole transaction
wnext  output  1  granted channel advances ch_wdata next cycle
rdata  output  32  read data to granted channel
rvalid  output  1  rdata valid (one per read beat)
done  output  1  one-cycle pulse, transaction complete
err  output  1  one-cycle pulse with done, transaction ended on ERROR
HADDR  output  32  AHB address
HBURST  output  3  AHB burst type
HMASTLOCK  output  1  constant 0
HPROT  output  4  4'b0010 for ch0 (opcode fetch), 4'b0011 otherwise
HSIZE  output  3  AHB size
HTRANS  output  2  IDLE=00, NONSEQ=10, SEQ=11
HWDATA  output  32  AHB write data
HWRITE  output  1  AHB direction
HRDATA  input  32  AHB read data
HREADY  input  1  AHB ready
HRESP  input  1  AHB response (1 = ERROR)

Behaviour:
- Reset (sync): state IDLE. Outputs: HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, HBURST=000, HSIZE=010, ch_gnt=0, rvalid/done/err/wnext=0; RR pointer = NUM_CH-1. Reset mid-burst drops the transaction with no done.
- States: IDLE, BUS (address/data pipeline active), DRAIN (last data phase only), ERR2 (second ERROR cycle).
- IDLE: arbitrate only here. If any ch_req is high, at the next edge:
  - register ch_gnt and the winner's addr/size/write/beats;
  - HTRANS=NONSEQ, HADDR=ch_addr;
  - HBURST = 000 for 1 beat, 011 for 4, 101 for 8, 111 for 16, 001 otherwise;
  - go to BUS.
  Arbitration: FIXED picks the lowest index. RR picks the first requester after the pointer; the pointer updates at grant.
- Address phase accepted = HTRANS≠IDLE && HREADY.
  - On accept with beats remaining: next HADDR = HADDR + (1<<HSIZE), HTRANS=SEQ.
  - On accept of the last address: HTRANS=IDLE, go to DRAIN.
  - Hold all address signals while HREADY=0.
- Write data: on each accepted address phase, HWDATA <= ch_wdata of the granted channel, and wnext=1 in that same cycle.
- Read data: each data phase completing with HREADY=1 and HRESP=0 gives rvalid=1 and rdata=HRDATA (combinational pass-through) in that cycle.
- Completion: the last data phase completes (DRAIN && HREADY && !HRESP). done=1 that cycle; next edge clears ch_gnt and returns to IDLE. There is at least one IDLE bus cycle between transactions.
- ERROR: HRESP=1 && HREADY=0 in a data phase.
  - Next edge: HTRANS=IDLE (remaining beats cancelled), go to ERR2.
  - In ERR2, when HRESP=1 && HREADY=1: done=1, err=1, rvalid=0; next edge returns to IDLE.
- Bursts never cross a 1 KB boundary; requesters align cache-line fills. Address arithmetic is 32-bit wrap-around.
- A requester deasserting ch_req mid-transaction is ignored; the transaction completes.
- Simultaneous done and new request: the new grant is taken one cycle later, from IDLE.

Test Plan:
- Single read: ch1 req, addr 0x100, size 2, beats 1, HREADY=1, HRDATA=0xDEADBEEF → NONSEQ/HBURST=000 at 0x100; next cycle rvalid with rdata=0xDEADBEEF and done=1; HPROT=0011.
- INCR4 read with waits: ch0 addr 0x40, beats 4, HREADY low 2 cycles on beat 2 → HADDR 0x40/44/48/4C with NONSEQ,SEQ,SEQ,SEQ, HBURST=011, HPROT=0010, address held during wait, exactly 4 rvalid, done on the 4th.
- Write INCR8: ch1 write at 0x200, wdata 1..8 advanced on wnext → HWDATA sequence 1..8 one cycle after each address accept, HBURST=101, done after the 8th data phase.
- ERROR: read beats 4, slave returns HRESP=1/HREADY=0 then HRESP=1/HREADY=1 on beat 2 → HTRANS=IDLE the cycle after the first ERROR cycle, done=err=1 on the second, only 1 rvalid.
- Arbitration: ch0 and ch1 req every cycle. FIXED → ch0 always granted. RR → grants alternate ch0, ch1, ch0.
- Reset mid-burst: assert reset during beat 3 of an INCR8 → next edge HTRANS=00, ch_gnt=0, no done; a new request after reset starts a fresh NONSEQ.

Source files
------------

// File: rtl/ahb_master_biu.sv
// AHB-Lite master bus interface unit: arbitrates NUM_CH requesters onto one
// AHB master port with pipelined address/data phases, waits and two-cycle ERROR.
module ahb_master_biu #(
   parameter int    NUM_CH    = 2,
   parameter int    MAX_BEATS = 8,
   parameter string ARB_MODE  = "FIXED"
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    ch_req,
   input  logic [NUM_CH*32-1:0] ch_addr,
   input  logic [NUM_CH-1:0]    ch_write,
   input  logic [NUM_CH*3-1:0]  ch_size,
   input  logic [NUM_CH*5-1:0]  ch_beats,
   input  logic [NUM_CH*32-1:0] ch_wdata,
   output logic [NUM_CH-1:0]    ch_gnt,
   output logic                 wnext,
   output logic [31:0]          rdata,
   output logic                 rvalid,
   output logic                 done,
   output logic                 err,
   output logic [31:0]          HADDR,
   output logic [2:0]           HBURST,
   output logic                 HMASTLOCK,
   output logic [3:0]           HPROT,
   output logic [2:0]           HSIZE,
   output logic [1:0]           HTRANS,
   output logic [31:0]          HWDATA,
   output logic                 HWRITE,
   input  logic [31:0]          HRDATA,
   input  logic                 HREADY,
   input  logic                 HRESP
);
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DRAIN, S_ERR2} state_t;

   state_t            state_q, state_d;
   logic [NUM_CH-1:0] gnt_q, gnt_d;
   logic [IW-1:0]     idx_q, idx_d, rr_q, rr_d;
   logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
   logic [1:0]        trans_q, trans_d;
   logic [2:0]        size_q, size_d, burst_q, burst_d;
   logic              write_q, write_d, dph_q, dph_d;
   logic [4:0]        left_q, left_d;

   logic [IW-1:0] win;
   logic          found;
   logic [31:0]   w_addr, g_wdata;
   logic [2:0]    w_size, w_burst;
   logic          w_write;
   logic [4:0]    w_raw, w_beats;
   logic          accept, dphase;

   // RR searches strictly above the last grant first, then wraps to the lowest index
   always_comb begin
      win   = '0;
      found = 1'b0;
      if (ARB_MODE == "RR") begin
         for (int i = NUM_CH-1; i >= 0; i--)
            if (ch_req[i] && i > int'(rr_q)) begin
               win   = IW'(i);
               found = 1'b1;
            end
         if (!found)
            for (int i = NUM_CH-1; i >= 0; i--)
               if (ch_req[i]) win = IW'(i);
      end else begin
         for (int i = NUM_CH-1; i >= 0; i--)
            if (ch_req[i]) win = IW'(i);
      end
   end

   always_comb begin
      w_addr  = '0;
      w_size  = '0;
      w_write = 1'b0;
      w_raw   = '0;
      g_wdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (IW'(i) == win) begin
            w_addr  = ch_addr[32*i +: 32];
            w_size  = ch_size[3*i +: 3];
            w_write = ch_write[i];
            w_raw   = ch_beats[5*i +: 5];
         end
         if (IW'(i) == idx_q) g_wdata = ch_wdata[32*i +: 32];
      end
      if (w_raw == 5'd0)                  w_beats = 5'd1;
      else if (w_raw > 5'(MAX_BEATS))     w_beats = 5'(MAX_BEATS);
      else                                w_beats = w_raw;
      case (w_beats)
         5'd1:    w_burst = 3'b000;
         5'd4:    w_burst = 3'b011;
         5'd8:    w_burst = 3'b101;
         5'd16:   w_burst = 3'b111;
         default: w_burst = 3'b001;
      endcase
   end

   assign accept = (trans_q != T_IDLE) && HREADY;
   assign dphase = (state_q == S_BUS && dph_q) || (state_q == S_DRAIN);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      rr_d    = rr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      trans_d = trans_q;
      size_d  = size_q;
      burst_d = burst_q;
      write_d = write_q;
      dph_d   = dph_q;
      left_d  = left_q;
      rvalid  = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      wnext   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|ch_req) begin
               gnt_d   = NUM_CH'(1) << win;
               idx_d   = win;
               rr_d    = win;
               addr_d  = w_addr;
               size_d  = w_size;
               write_d = w_write;
               burst_d = w_burst;
               left_d  = w_beats - 5'd1;
               trans_d = T_NONSEQ;
               dph_d   = 1'b0;
               state_d = S_BUS;
            end
         end
         S_BUS: begin
            if (dphase && HRESP && !HREADY) begin
               trans_d = T_IDLE;
               state_d = S_ERR2;
            end else begin
               rvalid = dphase && HREADY && !HRESP && !write_q;
               if (accept) begin
                  dph_d = 1'b1;
                  if (write_q) begin
                     wdata_d = g_wdata;
                     wnext   = 1'b1;
                  end
                  if (left_q == 5'd0) begin
                     trans_d = T_IDLE;
                     state_d = S_DRAIN;
                  end else begin
                     addr_d  = addr_q + (32'd1 << size_q);
                     trans_d = T_SEQ;
                     left_d  = left_q - 5'd1;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (HREADY && !HRESP) begin
               rvalid  = !write_q;
               done    = 1'b1;
               gnt_d   = '0;
               state_d = S_IDLE;
            end else if (HRESP && !HREADY) begin
               state_d = S_ERR2;
            end
         end
         S_ERR2: begin
            if (HRESP && HREADY) begin
               done    = 1'b1;
               err     = 1'b1;
               gnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         rr_q    <= IW'(NUM_CH-1);
         addr_q  <= '0;
         wdata_q <= '0;
         trans_q <= T_IDLE;
         size_q  <= 3'b010;
         burst_q <= 3'b000;
         write_q <= 1'b0;
         dph_q   <= 1'b0;
         left_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         rr_q    <= rr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         trans_q <= trans_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         write_q <= write_d;
         dph_q   <= dph_d;
         left_q  <= left_d;
      end
   end

   assign ch_gnt    = gnt_q;
   assign rdata     = HRDATA;
   assign HADDR     = addr_q;
   assign HBURST    = burst_q;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = (idx_q == '0) ? 4'b0010 : 4'b0011;
   assign HSIZE     = size_q;
   assign HTRANS    = trans_q;
   assign HWDATA    = wdata_q;
   assign HWRITE    = write_q;
endmodule

// File: tb/tb_ahb_master_biu.sv
// Scoreboard bench for ahb_master_biu: transaction-level model fills expected
// queues, a bus monitor pops and compares; the slave model inserts waits/errors.
module tb_ahb_master_biu;
   localparam int    NUM_CH    = 3;
   localparam int    MAX_BEATS = 8;
   localparam string ARB       = "RR";
   localparam int    AW        = 46 + NUM_CH;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NUM_CH-1:0]    ch_req, ch_write, ch_gnt;
   logic [NUM_CH*32-1:0] ch_addr, ch_wdata;
   logic [NUM_CH*3-1:0]  ch_size;
   logic [NUM_CH*5-1:0]  ch_beats;
   logic                 wnext, rvalid, done, err, HMASTLOCK, HWRITE, HREADY, HRESP;
   logic [31:0]          rdata, HADDR, HWDATA, HRDATA;
   logic [2:0]           HBURST, HSIZE;
   logic [3:0]           HPROT;
   logic [1:0]           HTRANS;

   logic [31:0] a_arr[NUM_CH], wd[NUM_CH];
   logic [2:0]  s_arr[NUM_CH];
   logic [4:0]  b_arr[NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
      assign ch_addr[32*g +: 32]  = a_arr[g];
      assign ch_wdata[32*g +: 32] = wd[g];
      assign ch_size[3*g +: 3]    = s_arr[g];
      assign ch_beats[5*g +: 5]   = b_arr[g];
   end

   ahb_master_biu #(.NUM_CH(NUM_CH), .MAX_BEATS(MAX_BEATS), .ARB_MODE(ARB)) dut (
      .clk(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr), .ch_write(ch_write),
      .ch_size(ch_size), .ch_beats(ch_beats), .ch_wdata(ch_wdata), .ch_gnt(ch_gnt),
      .wnext(wnext), .rdata(rdata), .rvalid(rvalid), .done(done), .err(err),
      .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE),
      .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA),
      .HREADY(HREADY), .HRESP(HRESP));

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   logic [AW-1:0]     q_addr[$];
   logic [31:0]       q_rd[$], q_wd[$];
   logic [NUM_CH:0]   q_done[$];
   int rr_ptr, err_beat, err_phase, beat_cnt;
   bit no_wait;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   function automatic logic [2:0] burst_of(input int n);
      case (n)
         1: return 3'b000;
         4: return 3'b011;
         8: return 3'b101;
         16: return 3'b111;
         default: return 3'b001;
      endcase
   endfunction

   function automatic int pick(input logic [NUM_CH-1:0] m);
      if (ARB == "RR") begin
         for (int k = 1; k <= NUM_CH; k++)
            if (m[(rr_ptr + k) % NUM_CH]) return (rr_ptr + k) % NUM_CH;
      end else begin
         for (int c = 0; c < NUM_CH; c++) if (m[c]) return c;
      end
      return 0;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic fail1(input string nm);
      vectors++;
      miscompares++;
      $display("FAIL %s: unexpected event (t=%0t)", nm, $time);
   endtask

   // Transaction-level expectation: address beats, data beats, completion.
   task automatic push_exp(input int ch, input logic [31:0] addr, input logic wr,
                           input logic [2:0] sz, input logic [4:0] braw,
                           input logic [31:0] wbase, input int eb);
      int n, na, nd;
      logic [NUM_CH-1:0] gnt;
      logic [3:0] prot;
      logic [31:0] a;
      n    = (braw == 0) ? 1 : ((braw > MAX_BEATS) ? MAX_BEATS : int'(braw));
      na   = (eb >= 0) ? eb + 1 : n;
      nd   = (eb >= 0) ? eb : n;
      gnt  = NUM_CH'(1) << ch;
      prot = (ch == 0) ? 4'b0010 : 4'b0011;
      for (int i = 0; i < na; i++) begin
         a = addr + (32'(i) << sz);
         q_addr.push_back({1'b0, (i == 0) ? 2'b10 : 2'b11, a, burst_of(n), sz, wr, prot, gnt});
      end
      for (int i = 0; i < nd; i++)
         if (wr) q_wd.push_back(wbase + 32'(i));
         else    q_rd.push_back(hash(addr + (32'(i) << sz)));
      q_done.push_back({eb >= 0, gnt});
      rr_ptr = ch;
   endtask

   task automatic wait_done();
      bit got = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         got = done;
      end
      if (!got) fail1("done_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic setup_ch(input logic [1:0] ch, input logic [31:0] addr, input logic wr,
                           input logic [2:0] sz, input logic [4:0] b, input logic [31:0] wbase);
      a_arr[ch]    = addr;
      ch_write[ch] = wr;
      s_arr[ch]    = sz;
      b_arr[ch]    = b;
      wd[ch]       = wbase;
   endtask

   task automatic run_txn(input logic [1:0] ch, input logic [31:0] addr, input logic wr,
                          input logic [2:0] sz, input logic [4:0] b, input int eb,
                          input logic [31:0] wbase);
      setup_ch(ch, addr, wr, sz, b, wbase);
      err_beat  = eb;
      err_phase = 0;
      beat_cnt  = 0;
      push_exp(int'(ch), addr, wr, sz, b, wbase, eb);
      ch_req[ch] = 1'b1;
      wait_done();
      ch_req[ch] = 1'b0;
   endtask

   // Slave: tracks its own data phase; read data is a hash of the accepted address.
   initial begin : slave
      logic acc, cmp, rs, sdp;
      logic [31:0] a, sdp_addr;
      int sdp_beat;
      sdp = 1'b0; sdp_addr = '0; sdp_beat = 0;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
      forever begin
         @(negedge clk);
         acc = (HTRANS != 2'b00) && HREADY;
         a   = HADDR;
         cmp = sdp && HREADY;
         rs  = reset;
         @(posedge clk);
         #1;
         if (rs) begin
            sdp = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
            continue;
         end
         if (cmp) sdp = 1'b0;
         if (acc) begin
            sdp = 1'b1; sdp_addr = a; sdp_beat = beat_cnt; beat_cnt++;
         end
         if (err_phase == 1) begin
            HRESP = 1'b1; HREADY = 1'b1; err_phase = 2;
         end else begin
            HRESP = 1'b0;
            if (sdp && sdp_beat == err_beat && err_phase == 0) begin
               HRESP = 1'b1; HREADY = 1'b0; err_phase = 1;
            end else begin
               HREADY = no_wait ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
         end
         HRDATA = sdp ? hash(sdp_addr) : $urandom;
      end
   end

   // Requester side: advance the granted channel's write word after wnext.
   initial begin : wdrv
      logic adv;
      logic [NUM_CH-1:0] g;
      forever begin
         @(negedge clk);
         adv = wnext;
         g   = ch_gnt;
         @(posedge clk);
         #1;
         if (adv)
            for (int c = 0; c < NUM_CH; c++)
               if (g[c]) wd[c] = wd[c] + 32'd1;
      end
   end

   initial begin : monitor
      bit dp, dpw, prev_err, prev_done;
      dp = 0; dpw = 0; prev_err = 0; prev_done = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            dp = 0; prev_err = 0; prev_done = 0;
            continue;
         end
         if (prev_err)  chk("htrans_after_error", 64'(HTRANS), 64'd0);
         if (prev_done) chk("idle_after_done", 64'({HTRANS, ch_gnt}), 64'd0);
         prev_err  = dp && HRESP && !HREADY;
         prev_done = done;
         if (HTRANS != 2'b00 && HREADY) begin
            if (q_addr.size() == 0) fail1("addr_phase");
            else chk("addr_phase", 64'({HMASTLOCK, HTRANS, HADDR, HBURST, HSIZE, HWRITE, HPROT, ch_gnt}),
                     64'(q_addr.pop_front()));
         end
         if (dp && HREADY) begin
            if (!HRESP && dpw) begin
               if (q_wd.size() == 0) fail1("hwdata");
               else chk("hwdata", 64'(HWDATA), 64'(q_wd.pop_front()));
            end
            dp = 0;
         end
         if (HTRANS != 2'b00 && HREADY) begin
            dp = 1; dpw = HWRITE;
         end
         if (rvalid) begin
            if (q_rd.size() == 0) fail1("rdata");
            else chk("rdata", 64'(rdata), 64'(q_rd.pop_front()));
         end
         if (done) begin
            if (q_done.size() == 0) fail1("done");
            else chk("done_err_gnt", 64'({err, ch_gnt}), 64'(q_done.pop_front()));
         end else if (err) fail1("err_without_done");
      end
   end

   initial begin : stim
      int btab[8] = '{0, 1, 2, 3, 4, 5, 7, 8};
      logic [NUM_CH-1:0] m;
      logic [2:0] sz;
      logic [4:0] b;
      logic [31:0] addr;
      int n, eb, w;
      bit got;
      reset = 1'b1; ch_req = '0; ch_write = '0; no_wait = 1'b0;
      err_beat = -1; err_phase = 0; beat_cnt = 0; rr_ptr = NUM_CH - 1;
      for (int c = 0; c < NUM_CH; c++) setup_ch(2'(c), 32'h0, 1'b0, 3'd2, 5'd1, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_bus", 64'({HTRANS, HADDR, HBURST, HSIZE, HWRITE, ch_gnt}),
          64'({2'b00, 32'h0, 3'b000, 3'b010, 1'b0, {NUM_CH{1'b0}}}));
      chk("reset_misc", 64'({HWDATA, done, err, rvalid, wnext, HMASTLOCK}), 64'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      no_wait = 1'b1;
      run_txn(2'd1, 32'h100, 1'b0, 3'd2, 5'd1, -1, 32'h0);
      no_wait = 1'b0;
      run_txn(2'd0, 32'h40, 1'b0, 3'd2, 5'd4, -1, 32'h0);
      run_txn(2'd1, 32'h200, 1'b1, 3'd2, 5'd8, -1, 32'd1);
      run_txn(2'd1, 32'h300, 1'b0, 3'd2, 5'd4, 1, 32'h0);
      run_txn(2'd0, 32'h80, 1'b0, 3'd2, 5'd0, -1, 32'h0);
      run_txn(2'd2, 32'h502, 1'b1, 3'd1, 5'd3, -1, 32'hA000);
      run_txn(2'd2, 32'h600, 1'b1, 3'd2, 5'd2, 0, 32'hB000);

      // Two requesters held high: grant order follows the arbitration model
      setup_ch(2'd0, 32'h800, 1'b0, 3'd2, 5'd2, 32'h0);
      setup_ch(2'd1, 32'h900, 1'b0, 3'd2, 5'd2, 32'h0);
      err_beat = -1; err_phase = 0;
      m = 3'b011;
      for (int r = 0; r < 6; r++) begin
         w = pick(m);
         beat_cnt = 0;
         push_exp(w, a_arr[w], 1'b0, 3'd2, 5'd2, 32'h0, -1);
         if (r == 0) ch_req = m;
         wait_done();
         a_arr[w] = a_arr[w] + 32'h10;
      end
      ch_req = '0;
      @(posedge clk);
      #1;

      // Reset in the middle of an INCR8 read
      setup_ch(2'd0, 32'h400, 1'b0, 3'd2, 5'd8, 32'h0);
      err_beat = -1; err_phase = 0; beat_cnt = 0;
      push_exp(0, 32'h400, 1'b0, 3'd2, 5'd8, 32'h0, -1);
      ch_req[0] = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         got = (beat_cnt >= 3);
      end
      if (!got) fail1("reset_wait_timeout");
      @(posedge clk);
      #1;
      reset = 1'b1;
      ch_req = '0;
      q_addr.delete(); q_rd.delete(); q_wd.delete(); q_done.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      rr_ptr = NUM_CH - 1;
      @(negedge clk);
      chk("reset_mid_burst", 64'({HTRANS, ch_gnt, done, HADDR}), 64'd0);
      @(posedge clk);
      #1;
      run_txn(2'd1, 32'h700, 1'b0, 3'd2, 5'd4, -1, 32'h0);

      for (int t = 0; t < 40; t++) begin
         sz   = 3'($urandom_range(0, 2));
         b    = 5'(btab[$urandom_range(0, 7)]);
         n    = (b == 0) ? 1 : int'(b);
         addr = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 63)) << sz);
         eb   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1;
         run_txn(2'($urandom_range(0, NUM_CH - 1)), addr, 1'($urandom_range(0, 1)),
                 sz, b, eb, $urandom);
      end

      repeat (3) @(posedge clk);
      chk("addr_queue_empty", 64'(q_addr.size()), 64'd0);
      chk("rdata_queue_empty", 64'(q_rd.size()), 64'd0);
      chk("wdata_queue_empty", 64'(q_wd.size()), 64'd0);
      chk("done_queue_empty", 64'(q_done.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
